// File: rtl/pifo_flow_scheduler.sv
// Per-flow packet scheduler driving an attached pifo_set.
// Keeps one PIFO entry per backlogged flow; reinserts the head while it still has packets.
module pifo_flow_scheduler #(
  parameter int NUM_FLOWS    = 16,
  parameter int MAX_PRIORITY = 256,
  parameter int PRIO_WIDTH   = $clog2(MAX_PRIORITY),
  parameter int FLOW_WIDTH   = $clog2(NUM_FLOWS + 1),
  parameter int CNT_WIDTH    = 8,
  parameter int BL_WIDTH     = CNT_WIDTH + $clog2(NUM_FLOWS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__enable,
  input  logic                  i__flush,
  input  logic                  i__arr_valid,
  input  logic [FLOW_WIDTH-1:0] i__arr_flow_id,
  output logic                  o__arr_ready,
  input  logic                  i__deq_req,
  output logic                  o__deq_ready,
  output logic                  o__deq_valid,
  output logic [FLOW_WIDTH-1:0] o__deq_flow_id,
  output logic [BL_WIDTH-1:0]   o__backlog,
  input  logic                  i__cfg_we,
  input  logic [FLOW_WIDTH-1:0] i__cfg_flow_id,
  input  logic [PRIO_WIDTH-1:0] i__cfg_priority,
  output logic                  o__pifo_push_valid,
  output logic [PRIO_WIDTH-1:0] o__pifo_push_priority,
  output logic [FLOW_WIDTH-1:0] o__pifo_push_flow_id,
  input  logic                  i__pifo_ready,
  input  logic                  i__pifo_pop_valid,
  input  logic [FLOW_WIDTH-1:0] i__pifo_pop_flow_id,
  output logic                  o__pifo_pop,
  output logic                  o__pifo_reinsert_valid,
  output logic [PRIO_WIDTH-1:0] o__pifo_reinsert_priority,
  output logic                  o__pifo_clear_all
);

  localparam int IW = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1;
  localparam logic [FLOW_WIDTH-1:0] NF = FLOW_WIDTH'(NUM_FLOWS);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt     [NUM_FLOWS];
  logic [CNT_WIDTH-1:0]  cnt_nxt [NUM_FLOWS];
  logic [NUM_FLOWS-1:0]  active;
  logic [PRIO_WIDTH-1:0] prio    [NUM_FLOWS];

  logic [IW-1:0] fi;
  logic [IW-1:0] hi;
  logic [IW-1:0] ci;
  logic          f_ok;
  logic          h_ok;
  logic          c_ok;
  logic          flushing;
  logic          grant;
  logic          head_hit;
  logic          accept;

  assign fi = i__arr_flow_id[IW-1:0];
  assign hi = i__pifo_pop_flow_id[IW-1:0];
  assign ci = i__cfg_flow_id[IW-1:0];

  assign f_ok = i__arr_flow_id < NF;
  assign h_ok = i__pifo_pop_flow_id < NF;
  assign c_ok = i__cfg_flow_id < NF;

  assign flushing = state == FLUSH;

  assign o__deq_ready = (state == RUN) && i__pifo_pop_valid && h_ok;
  assign grant = i__deq_req && o__deq_ready;

  // The head flow being dequeued needs no PIFO slot: its reinsert covers it.
  assign head_hit = grant && (i__arr_flow_id == i__pifo_pop_flow_id);

  assign o__arr_ready = !flushing && f_ok
                     && (cnt[fi] != '1)
                     && (active[fi] || i__pifo_ready || head_hit);
  assign accept = i__arr_valid && o__arr_ready;

  assign o__pifo_push_valid    = accept && !active[fi] && !head_hit;
  assign o__pifo_push_priority = prio[fi];
  assign o__pifo_push_flow_id  = i__arr_flow_id;

  assign o__pifo_pop = grant;
  assign o__pifo_reinsert_valid = grant
    && ((cnt[hi] > CNT_WIDTH'(1)) || (accept && head_hit));
  assign o__pifo_reinsert_priority = prio[hi];

  assign o__pifo_clear_all = flushing;

  // Next per-flow packet count: +1 on arrival, -1 on grant, unchanged if both.
  always_comb begin
    for (int g = 0; g < NUM_FLOWS; g++) begin
      cnt_nxt[g] = cnt[g];
      if (accept && fi == IW'(g) && !(grant && hi == IW'(g)))
        cnt_nxt[g] = cnt[g] + CNT_WIDTH'(1);
      else if (grant && hi == IW'(g) && !(accept && fi == IW'(g)))
        cnt_nxt[g] = cnt[g] - CNT_WIDTH'(1);
    end
  end

  // Control FSM, per-flow counts, backlog and the registered grant outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      active         <= '0;
      o__backlog     <= '0;
      o__deq_valid   <= 1'b0;
      o__deq_flow_id <= '0;
      for (int g = 0; g < NUM_FLOWS; g++)
        cnt[g] <= '0;
    end else begin
      o__deq_valid <= grant;
      if (grant)
        o__deq_flow_id <= i__pifo_pop_flow_id;

      if (i__flush && state != FLUSH) begin
        state <= FLUSH;
      end else begin
        unique case (state)
          IDLE:    if (i__enable) state <= RUN;
          RUN:     if (!i__enable) state <= IDLE;
          FLUSH:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      if (flushing) begin
        active     <= '0;
        o__backlog <= '0;
        for (int g = 0; g < NUM_FLOWS; g++)
          cnt[g] <= '0;
      end else begin
        for (int g = 0; g < NUM_FLOWS; g++) begin
          cnt[g]    <= cnt_nxt[g];
          active[g] <= cnt_nxt[g] != '0;
        end
        if (accept && !grant)
          o__backlog <= o__backlog + BL_WIDTH'(1);
        else if (grant && !accept)
          o__backlog <= o__backlog - BL_WIDTH'(1);
      end
    end
  end

  // Priority table; survives flush, new values apply to later inserts only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int g = 0; g < NUM_FLOWS; g++)
        prio[g] <= '0;
    end else if (i__cfg_we && c_ok) begin
      prio[ci] <= i__cfg_priority;
    end
  end

endmodule

// File: tb/tb_pifo_flow_scheduler.sv
// Directed bench for pifo_flow_scheduler with a behavioural pifo_set model.
// Expected grant order is queued as stimulus is applied and checked on deq_valid.
module tb_pifo_flow_scheduler;

  localparam int NF = 16;
  localparam int PW = 8;
  localparam int FW = 5;
  localparam int BW = 12;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic          arr_valid = 1'b0;
  logic [FW-1:0] arr_flow = '0;
  logic          arr_ready;
  logic          deq_req = 1'b0;
  logic          deq_ready;
  logic          deq_valid;
  logic [FW-1:0] deq_flow;
  logic [BW-1:0] backlog;
  logic          cfg_we = 1'b0;
  logic [FW-1:0] cfg_flow = '0;
  logic [PW-1:0] cfg_prio = '0;
  logic          push_valid;
  logic [PW-1:0] push_prio;
  logic [FW-1:0] push_flow;
  logic          pifo_ready = 1'b1;
  logic          pop_valid = 1'b0;
  logic [FW-1:0] pop_flow = '0;
  logic          pop;
  logic          rein_valid;
  logic [PW-1:0] rein_prio;
  logic          clear_all;

  int n_assert = 0;
  int n_fail = 0;
  int sb[$];

  typedef struct {
    int unsigned p;
    int unsigned f;
  } ent_t;
  ent_t q[$];
  bit   dup;

  always #5 clk = ~clk;

  pifo_flow_scheduler dut (
    .clk                       (clk),
    .reset                     (reset),
    .i__enable                 (enable),
    .i__flush                  (flush),
    .i__arr_valid              (arr_valid),
    .i__arr_flow_id            (arr_flow),
    .o__arr_ready              (arr_ready),
    .i__deq_req                (deq_req),
    .o__deq_ready              (deq_ready),
    .o__deq_valid              (deq_valid),
    .o__deq_flow_id            (deq_flow),
    .o__backlog                (backlog),
    .i__cfg_we                 (cfg_we),
    .i__cfg_flow_id            (cfg_flow),
    .i__cfg_priority           (cfg_prio),
    .o__pifo_push_valid        (push_valid),
    .o__pifo_push_priority     (push_prio),
    .o__pifo_push_flow_id      (push_flow),
    .i__pifo_ready             (pifo_ready),
    .i__pifo_pop_valid         (pop_valid),
    .i__pifo_pop_flow_id       (pop_flow),
    .o__pifo_pop               (pop),
    .o__pifo_reinsert_valid    (rein_valid),
    .o__pifo_reinsert_priority (rein_prio),
    .o__pifo_clear_all         (clear_all)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // New entries go behind every entry of equal or higher priority.
  function automatic void ins(input int unsigned p, input int unsigned f);
    int i = 0;
    while (i < q.size() && q[i].p >= p) i++;
    q.insert(i, '{p: p, f: f});
  endfunction

  // Behavioural pifo_set: pop, then push, then reinsert of the popped flow.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
    end else if (clear_all) begin
      q.delete();
    end else begin
      if (pop && q.size() > 0)
        void'(q.pop_front());
      if (push_valid) begin
        dup = 1'b0;
        foreach (q[i]) if (q[i].f == push_flow) dup = 1'b1;
        chk("push_of_active_flow", 32'(dup), 0);
        ins(push_prio, push_flow);
        chk("pifo_occupancy_ok", 32'(q.size() <= NF), 1);
      end
      if (rein_valid)
        ins(rein_prio, pop_flow);
    end
    pop_valid  <= q.size() > 0;
    pop_flow   <= (q.size() > 0) ? FW'(q[0].f) : '0;
    pifo_ready <= q.size() < NF;
  end

  // Every grant must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && deq_valid) begin
      if (sb.size() == 0) chk("deq_unexpected", deq_flow, 32'hFFFF);
      else chk("deq_order", deq_flow, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int f, input int p);
    cfg_we = 1'b1;
    cfg_flow = FW'(f);
    cfg_prio = PW'(p);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic arrive(input int f);
    arr_valid = 1'b1;
    arr_flow = FW'(f);
    #1 chk("arr_ready", arr_ready, 1);
    tick();
    arr_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    deq_req = 1'b1;
    repeat (n) tick();
    deq_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_clear_all", clear_all, 1);
    chk("flush_arr_ready", arr_ready, 0);
    chk("flush_deq_ready", deq_ready, 0);
    tick();
    #1;
    chk("flush_backlog", backlog, 0);
    chk("flush_clear_one", clear_all, 0);
    chk("flush_deq_ready_after", deq_ready, 0);
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_backlog", backlog, 0);
    chk("rst_deq_valid", deq_valid, 0);
    chk("rst_deq_flow", deq_flow, 0);
    chk("rst_clear_all", clear_all, 0);
    chk("rst_push", push_valid, 0);
    chk("rst_deq_ready", deq_ready, 0);
    reset = 1'b0;
    enable = 1'b1;

    // 1: two packets on flow 3, one push, reinsert only on first grant
    cfg(3, 10);
    arr_valid = 1'b1;
    arr_flow = 3;
    #1;
    chk("t1_push_valid", push_valid, 1);
    chk("t1_push_flow", push_flow, 3);
    chk("t1_push_prio", push_prio, 10);
    tick();
    #1;
    chk("t1_no_second_push", push_valid, 0);
    chk("t1_arr_ready2", arr_ready, 1);
    tick();
    arr_valid = 1'b0;
    #1 chk("t1_backlog2", backlog, 2);
    sb.push_back(3);
    sb.push_back(3);
    deq_req = 1'b1;
    #1;
    chk("t1_deq_ready1", deq_ready, 1);
    chk("t1_pop1", pop, 1);
    chk("t1_reinsert1", rein_valid, 1);
    chk("t1_reinsert_prio", rein_prio, 10);
    tick();
    #1;
    chk("t1_deq_ready2", deq_ready, 1);
    chk("t1_pop2", pop, 1);
    chk("t1_reinsert2", rein_valid, 0);
    tick();
    #1;
    chk("t1_deq_ready3", deq_ready, 0);
    chk("t1_pop3", pop, 0);
    chk("t1_backlog0", backlog, 0);
    tick();
    deq_req = 1'b0;
    tick();

    // 2: equal priorities round-robin
    cfg(1, 5);
    cfg(2, 5);
    arrive(1);
    arrive(1);
    arrive(2);
    arrive(2);
    sb.push_back(1);
    sb.push_back(2);
    sb.push_back(1);
    sb.push_back(2);
    drain(4);

    // 3: strict priority
    cfg(4, 200);
    cfg(5, 50);
    for (int i = 0; i < 3; i++) arrive(4);
    for (int i = 0; i < 3; i++) arrive(5);
    for (int i = 0; i < 3; i++) sb.push_back(4);
    for (int i = 0; i < 3; i++) sb.push_back(5);
    drain(6);

    // 4: arrival to head during grant, then push of new flow during grant
    cfg(6, 20);
    cfg(7, 30);
    arrive(6);
    arr_valid = 1'b1;
    arr_flow = 6;
    deq_req = 1'b1;
    sb.push_back(6);
    #1;
    chk("t4_pop_a", pop, 1);
    chk("t4_reinsert_a", rein_valid, 1);
    chk("t4_reinsert_prio_a", rein_prio, 20);
    chk("t4_no_push_a", push_valid, 0);
    tick();
    arr_flow = 7;
    sb.push_back(6);
    #1;
    chk("t4_pop_b", pop, 1);
    chk("t4_reinsert_b", rein_valid, 0);
    chk("t4_push_b", push_valid, 1);
    chk("t4_push_flow_b", push_flow, 7);
    chk("t4_push_prio_b", push_prio, 30);
    tick();
    arr_valid = 1'b0;
    sb.push_back(7);
    #1 chk("t4_backlog1", backlog, 1);
    tick();
    deq_req = 1'b0;
    tick();
    tick();
    chk("t4_backlog0", backlog, 0);

    // 5: saturated flow counter blocks only that flow
    for (int i = 0; i < 255; i++) arrive(2);
    arr_valid = 1'b1;
    arr_flow = 2;
    #1 chk("t5_full_blocked", arr_ready, 0);
    arr_flow = 3;
    #1 chk("t5_other_ok", arr_ready, 1);
    tick();
    arr_valid = 1'b0;
    #1 chk("t5_backlog", backlog, 256);
    do_flush();

    // 6: flush with backlog, then fresh push with retained priority
    arrive(1);
    arrive(1);
    arrive(2);
    arrive(2);
    arrive(3);
    #1 chk("t6_backlog5", backlog, 5);
    do_flush();
    arr_valid = 1'b1;
    arr_flow = 3;
    #1;
    chk("t6_fresh_push", push_valid, 1);
    chk("t6_fresh_flow", push_flow, 3);
    chk("t6_fresh_prio", push_prio, 10);
    tick();
    arr_valid = 1'b0;
    enable = 1'b0;
    tick();
    #1 chk("t6_idle_no_deq", deq_ready, 0);
    enable = 1'b1;
    deq_req = 1'b1;
    sb.push_back(3);
    tick();
    tick();
    deq_req = 1'b0;
    tick();
    tick();
    chk("t6_backlog0", backlog, 0);

    // Asynchronous reset mid-operation
    arrive(5);
    arrive(5);
    reset = 1'b1;
    #1;
    chk("arst_backlog", backlog, 0);
    chk("arst_push", push_valid, 0);
    chk("arst_deq_valid", deq_valid, 0);
    tick();
    reset = 1'b0;
    tick();

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
